// File: rtl/el2_pmp_seq_checker.sv
// PMP register file with lock semantics, N registered check channels,
// first-fault capture and a saturating fault counter.
module el2_pmp_seq_checker #(
   parameter int PMP_ENTRIES  = 16,
   parameter int PMP_CHANNELS = 3,
   parameter int ERR_CNT_W    = 16,
   localparam int IDX_W = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1,
   localparam int CH_W  = $clog2(PMP_CHANNELS) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_we,
   input  logic [IDX_W-1:0]          cfg_idx,
   input  logic [7:0]                cfg_wdata,
   input  logic                      addr_we,
   input  logic [IDX_W-1:0]          addr_idx,
   input  logic [31:0]               addr_wdata,
   output logic [8*PMP_ENTRIES-1:0]  pmp_cfg_q,
   input  logic [PMP_CHANNELS-1:0]   chan_valid,
   input  logic [32*PMP_CHANNELS-1:0] chan_addr,
   input  logic [3*PMP_CHANNELS-1:0] chan_type,
   output logic [PMP_CHANNELS-1:0]   rsp_valid,
   output logic [PMP_CHANNELS-1:0]   rsp_err,
   output logic                      fault_valid,
   output logic [31:0]               fault_addr,
   output logic [CH_W-1:0]           fault_chan,
   output logic [2:0]                fault_type,
   input  logic                      fault_clr,
   output logic [ERR_CNT_W-1:0]      err_count
);

   logic [7:0]  cfg_q  [PMP_ENTRIES];
   logic [31:0] addr_q [PMP_ENTRIES];

   logic [PMP_ENTRIES-1:0] addr_lock;
   logic [31:0]            tor_lo [PMP_ENTRIES];

   logic [PMP_CHANNELS-1:0]   req_vld_p0;
   logic [32*PMP_CHANNELS-1:0] req_addr_p0;
   logic [3*PMP_CHANNELS-1:0] req_type_p0;
   logic [PMP_CHANNELS-1:0]   err_raw;

   logic                 fault_valid_q, fault_valid_d;
   logic [31:0]          fault_addr_q, fault_addr_d;
   logic [CH_W-1:0]      fault_chan_q, fault_chan_d;
   logic [2:0]           fault_type_q, fault_type_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [3:0]           err_pop;

   logic cfg_idx_ok, addr_idx_ok;
   logic unused_cfg_res;

   function automatic logic [7:0] cfg_legal(input logic [7:0] w);
      return {w[7], 2'b00, w[4:3], w[2], w[1] & w[0], w[0]};
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                    input logic [3:0] b);
      logic [ERR_CNT_W+3:0] s;
      s = {4'b0000, a} + {{ERR_CNT_W{1'b0}}, b};
      if (s > {4'b0000, {ERR_CNT_W{1'b1}}}) return {ERR_CNT_W{1'b1}};
      return s[ERR_CNT_W-1:0];
   endfunction

   assign unused_cfg_res = ^cfg_wdata[6:5];
   assign cfg_idx_ok  = 32'(cfg_idx)  < 32'(PMP_ENTRIES);
   assign addr_idx_ok = 32'(addr_idx) < 32'(PMP_ENTRIES);

   // An address is frozen by its own lock or by a locked TOR entry above it.
   for (genvar e = 0; e < PMP_ENTRIES; e++) begin : g_ent
      assign pmp_cfg_q[8*e +: 8] = cfg_q[e];
      if (e + 1 < PMP_ENTRIES) begin : g_up
         assign addr_lock[e] = cfg_q[e][7] | (cfg_q[e+1][7] & (cfg_q[e+1][4:3] == 2'd1));
      end else begin : g_top
         assign addr_lock[e] = cfg_q[e][7];
      end
      if (e == 0) begin : g_lo0
         assign tor_lo[e] = 32'h0;
      end else begin : g_lon
         assign tor_lo[e] = addr_q[e-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int e = 0; e < PMP_ENTRIES; e++) begin
            cfg_q[e]  <= 8'h00;
            addr_q[e] <= 32'h0;
         end
      end else begin
         if (cfg_we && cfg_idx_ok && !cfg_q[cfg_idx][7])
            cfg_q[cfg_idx] <= cfg_legal(cfg_wdata);
         if (addr_we && addr_idx_ok && !addr_lock[addr_idx])
            addr_q[addr_idx] <= addr_wdata;
      end
   end

   // p0: registered request
   always_ff @(posedge clk) begin
      if (rst) req_vld_p0 <= '0;
      else     req_vld_p0 <= chan_valid;
   end

   always_ff @(posedge clk) begin
      req_addr_p0 <= chan_addr;
      req_type_p0 <= chan_type;
   end

   always_comb begin
      logic [31:0] wa;
      logic [31:0] a;
      logic [2:0]  typ;
      logic [2:0]  perm;
      logic        hit;
      logic        m;
      logic        onehot;
      err_raw = '0;
      for (int c = 0; c < PMP_CHANNELS; c++) begin
         wa   = {2'b00, req_addr_p0[32*c+2 +: 30]};
         typ  = req_type_p0[3*c +: 3];
         hit  = 1'b0;
         perm = 3'b000;
         for (int e = 0; e < PMP_ENTRIES; e++) begin
            a = addr_q[e];
            case (cfg_q[e][4:3])
               2'd1:    m = (tor_lo[e] < a) && (wa >= tor_lo[e]) && (wa < a);
               2'd2:    m = (wa == a);
               2'd3:    m = (((wa ^ a) & ~(a ^ (a + 32'd1))) == 32'h0);
               default: m = 1'b0;
            endcase
            if (m && !hit) begin
               hit  = 1'b1;
               perm = cfg_q[e][2:0];
            end
         end
         onehot = (typ == 3'b001) || (typ == 3'b010) || (typ == 3'b100);
         err_raw[c] = !onehot || (hit && ((typ & perm) == 3'b000));
      end
   end

   assign rsp_valid = req_vld_p0;
   assign rsp_err   = req_vld_p0 & err_raw;

   // p1: fault capture and error count
   always_comb begin
      fault_valid_d = fault_valid_q;
      fault_addr_d  = fault_addr_q;
      fault_chan_d  = fault_chan_q;
      fault_type_d  = fault_type_q;
      err_pop       = 4'd0;
      if (fault_clr) fault_valid_d = 1'b0;
      if ((!fault_valid_q || fault_clr) && (|rsp_err)) begin
         fault_valid_d = 1'b1;
         for (int c = PMP_CHANNELS - 1; c >= 0; c--) begin
            if (rsp_err[c]) begin
               fault_chan_d = CH_W'(c);
               fault_addr_d = req_addr_p0[32*c +: 32];
               fault_type_d = req_type_p0[3*c +: 3];
            end
         end
      end
      for (int c = 0; c < PMP_CHANNELS; c++) err_pop = err_pop + 4'(rsp_err[c]);
      err_cnt_d = sat_add(err_cnt_q, err_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_valid_q <= 1'b0;
         fault_addr_q  <= 32'h0;
         fault_chan_q  <= '0;
         fault_type_q  <= 3'b000;
         err_cnt_q     <= '0;
      end else begin
         fault_valid_q <= fault_valid_d;
         fault_addr_q  <= fault_addr_d;
         fault_chan_q  <= fault_chan_d;
         fault_type_q  <= fault_type_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign fault_valid = fault_valid_q;
   assign fault_addr  = fault_addr_q;
   assign fault_chan  = fault_chan_q;
   assign fault_type  = fault_type_q;
   assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_el2_pmp_seq_checker.sv
// Directed bench for el2_pmp_seq_checker: vector table plus lock, fault-capture
// and counter-saturation sequences.
module tb_el2_pmp_seq_checker;
   localparam int NE = 16;
   localparam int NC = 3;
   localparam int CW = 4;
   localparam logic [2:0] TR = 3'b001;
   localparam logic [2:0] TW = 3'b010;
   localparam logic [2:0] TX = 3'b100;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [3:0]    cfg_idx;
   logic [7:0]    cfg_wdata;
   logic          addr_we;
   logic [3:0]    addr_idx;
   logic [31:0]   addr_wdata;
   logic [8*NE-1:0] pmp_cfg_q;
   logic [NC-1:0] chan_valid;
   logic [32*NC-1:0] chan_addr;
   logic [3*NC-1:0] chan_type;
   logic [NC-1:0] rsp_valid;
   logic [NC-1:0] rsp_err;
   logic          fault_valid;
   logic [31:0]   fault_addr;
   logic [2:0]    fault_chan;
   logic [2:0]    fault_type;
   logic          fault_clr;
   logic [CW-1:0] err_count;

   int checks = 0;
   int errors = 0;

   el2_pmp_seq_checker #(.PMP_ENTRIES(NE), .PMP_CHANNELS(NC), .ERR_CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
      .addr_we(addr_we), .addr_idx(addr_idx), .addr_wdata(addr_wdata),
      .pmp_cfg_q(pmp_cfg_q),
      .chan_valid(chan_valid), .chan_addr(chan_addr), .chan_type(chan_type),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err),
      .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_chan(fault_chan),
      .fault_type(fault_type), .fault_clr(fault_clr), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          phase;
      logic [2:0]  vld;
      logic [31:0] a0, a1, a2;
      logic [2:0]  t0, t1, t2;
      logic [2:0]  exp_err;
   } vec_t;

   vec_t vecs[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic wr_cfg(input int idx, input logic [7:0] d);
      cfg_idx = 4'(idx); cfg_wdata = d; cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic wr_addr(input int idx, input logic [31:0] d);
      addr_idx = 4'(idx); addr_wdata = d; addr_we = 1'b1;
      step();
      addr_we = 1'b0;
   endtask

   task automatic drive(input logic [2:0] v, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [2:0] t0, input logic [2:0] t1,
                        input logic [2:0] t2);
      chan_valid = v;
      chan_addr  = {a2, a1, a0};
      chan_type  = {t2, t1, t0};
   endtask

   task automatic send(input logic [2:0] v, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [2:0] t0, input logic [2:0] t1,
                       input logic [2:0] t2);
      drive(v, a0, a1, a2, t0, t1, t2);
      step();
      chan_valid = '0;
   endtask

   task automatic configure(input int ph);
      chan_valid = '0;
      if (ph == 1) begin
         wr_addr(0, 32'h0000_01FF);
         wr_cfg(0, 8'h19);
         wr_cfg(2, 8'h1A);
         wr_cfg(3, 8'h6B);
         chk("cfg0 napot", 32'(pmp_cfg_q[7:0]), 32'h19);
         chk("cfg2 w_without_r", 32'(pmp_cfg_q[23:16]), 32'h18);
         chk("cfg3 reserved", 32'(pmp_cfg_q[31:24]), 32'h0B);
      end else if (ph == 2) begin
         wr_cfg(2, 8'h00);
         wr_cfg(3, 8'h00);
         wr_addr(0, 32'h400);
         wr_cfg(0, 8'h0F);
         wr_addr(1, 32'h800);
         wr_cfg(1, 8'h08);
      end
   endtask

   task automatic cfg_all_read_only();
      wr_addr(0, 32'hFFFF_FFFF);
      wr_cfg(0, 8'h19);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int cur;
      rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_wdata = '0;
      addr_we = 1'b0; addr_idx = '0; addr_wdata = '0;
      chan_valid = '0; chan_addr = '0; chan_type = '0; fault_clr = 1'b0;

      vecs[0] = '{0, 3'b111, 32'h0, 32'h1234, 32'hFFFF_FFFC, TR, TR, TR, 3'b000};
      vecs[1] = '{0, 3'b111, 32'h0, 32'h10, 32'h20, 3'b000, 3'b011, TR, 3'b011};
      vecs[2] = '{0, 3'b010, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 3'b000, 3'b010};
      vecs[3] = '{0, 3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 3'b000, 3'b000};
      vecs[4] = '{1, 3'b111, 32'h100, 32'hFFC, 32'h1000, TW, TR, TW, 3'b001};
      vecs[5] = '{1, 3'b111, 32'h0, 32'hFFC, 32'h1000, TX, TW, TR, 3'b011};
      vecs[6] = '{2, 3'b111, 32'h800, 32'h1000, 32'h2000, TX, TX, TX, 3'b010};
      vecs[7] = '{2, 3'b111, 32'h1FFC, 32'hFFC, 32'h1FFF, TR, TW, TR, 3'b101};

      step(); step();
      chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset rsp_err", 32'(rsp_err), 32'h0);
      chk("reset fault_valid", 32'(fault_valid), 32'h0);
      chk("reset fault_addr", fault_addr, 32'h0);
      chk("reset fault_chan", 32'(fault_chan), 32'h0);
      chk("reset fault_type", 32'(fault_type), 32'h0);
      chk("reset err_count", 32'(err_count), 32'h0);
      chk("reset cfg lo", pmp_cfg_q[31:0], 32'h0);
      rst = 1'b0;

      cur = 0;
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].phase != cur) begin
            configure(vecs[i].phase);
            cur = vecs[i].phase;
         end
         drive(vecs[i].vld, vecs[i].a0, vecs[i].a1, vecs[i].a2,
               vecs[i].t0, vecs[i].t1, vecs[i].t2);
         step();
         chan_valid = '0;
         chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].vld));
         chk($sformatf("vec%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
      end

      // Lock sequence on top of the TOR setup left by the last table phase.
      wr_cfg(1, 8'h88);
      chk("lock cfg1 set", 32'(pmp_cfg_q[15:8]), 32'h88);
      wr_addr(0, 32'h123);
      send(3'b001, 32'hFFC, 32'h0, 32'h0, TX, TR, TR);
      chk("lock addr0 held", 32'(rsp_err), 32'h0);
      wr_cfg(1, 8'h0F);
      chk("lock cfg1 held", 32'(pmp_cfg_q[15:8]), 32'h88);
      wr_addr(1, 32'h400);
      send(3'b001, 32'h1000, 32'h0, 32'h0, TX, TR, TR);
      chk("lock addr1 held", 32'(rsp_err), 32'h1);

      wr_addr(3, 32'hA00);
      cfg_idx = 4'd3; cfg_wdata = 8'h89; cfg_we = 1'b1;
      addr_idx = 4'd2; addr_wdata = 32'h900; addr_we = 1'b1;
      step();
      cfg_we = 1'b0; addr_we = 1'b0;
      chk("dual write cfg3", 32'(pmp_cfg_q[31:24]), 32'h89);
      send(3'b011, 32'h2000, 32'h2400, 32'h0, TW, TW, TR);
      chk("dual write addr2", 32'(rsp_err), 32'h2);
      wr_addr(2, 32'h0);
      send(3'b011, 32'h2000, 32'h2400, 32'h0, TW, TW, TR);
      chk("tor lock addr2 held", 32'(rsp_err), 32'h2);

      rst = 1'b1; step(); rst = 1'b0;
      chk("post rst cfg lo", pmp_cfg_q[31:0], 32'h0);
      wr_cfg(1, 8'h0F);
      chk("post rst cfg1 write", 32'(pmp_cfg_q[15:8]), 32'h0F);
      wr_addr(0, 32'h123);
      wr_cfg(0, 8'h0F);
      wr_addr(1, 32'h200);
      wr_cfg(1, 8'h08);
      send(3'b011, 32'h48C, 32'h488, 32'h0, TX, TX, TR);
      chk("post rst addr writes", 32'(rsp_err), 32'h1);

      // Fault capture ordering.
      rst = 1'b1; step(); rst = 1'b0;
      cfg_all_read_only();
      send(3'b111, 32'h1000, 32'h2000, 32'h3000, TW, TR, TW);
      chk("fc rsp_err A", 32'(rsp_err), 32'h5);
      chk("fc not yet valid", 32'(fault_valid), 32'h0);
      send(3'b010, 32'h0, 32'h4000, 32'h0, TR, TW, TR);
      chk("fc valid", 32'(fault_valid), 32'h1);
      chk("fc chan", 32'(fault_chan), 32'h0);
      chk("fc addr", fault_addr, 32'h1000);
      chk("fc type", 32'(fault_type), 32'(TW));
      chk("fc count 2", 32'(err_count), 32'h2);
      send(3'b010, 32'h0, 32'h5000, 32'h0, TR, TW, TR);
      chk("fc hold chan", 32'(fault_chan), 32'h0);
      chk("fc hold addr", fault_addr, 32'h1000);
      chk("fc count 3", 32'(err_count), 32'h3);
      fault_clr = 1'b1;
      step();
      chk("fc clr+new valid", 32'(fault_valid), 32'h1);
      chk("fc clr+new chan", 32'(fault_chan), 32'h1);
      chk("fc clr+new addr", fault_addr, 32'h5000);
      chk("fc count 4", 32'(err_count), 32'h4);
      step();
      fault_clr = 1'b0;
      chk("fc clr valid", 32'(fault_valid), 32'h0);
      chk("fc clr addr held", fault_addr, 32'h5000);
      chk("fc clr chan held", 32'(fault_chan), 32'h1);
      chk("fc clr count held", 32'(err_count), 32'h4);

      // Counter saturation.
      rst = 1'b1; step(); rst = 1'b0;
      cfg_all_read_only();
      drive(3'b001, 32'h40, 32'h0, 32'h0, TW, TR, TR);
      for (int i = 0; i < 10; i++) step();
      chan_valid = '0;
      step(); step();
      chk("sat count 10", 32'(err_count), 32'd10);
      drive(3'b001, 32'h40, 32'h0, 32'h0, TW, TR, TR);
      for (int i = 0; i < 10; i++) step();
      chan_valid = '0;
      step(); step();
      chk("sat count 15", 32'(err_count), 32'd15);
      drive(3'b001, 32'h40, 32'h0, 32'h0, TW, TR, TR);
      for (int i = 0; i < 3; i++) step();
      chk("sat holds", 32'(err_count), 32'd15);
      rst = 1'b1;
      cfg_idx = 4'd0; cfg_wdata = 8'h0F; cfg_we = 1'b1;
      step();
      rst = 1'b0; cfg_we = 1'b0; chan_valid = '0;
      chk("mid rst rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mid rst err_count", 32'(err_count), 32'h0);
      chk("mid rst cfg0", 32'(pmp_cfg_q[7:0]), 32'h0);
      step();
      chk("after rst count", 32'(err_count), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/el2_pmp_seq_checker.md
Name: el2_pmp_seq_checker

Overview:
Registered, parametrised PMP unit for the VeeR EL2 core. It owns the pmpcfg/pmpaddr register file, including write port and lock semantics, and checks N request channels against it with a fixed one-cycle response. It also captures the first access fault and keeps a saturating error count. It sits between the CSR block (config writes) and the LSU/IFU/DMA access paths (checks).

Parameters:
PMP_ENTRIES, 16, number of PMP entries (1..64)
PMP_CHANNELS, 3, number of independent check channels (1..8)
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_we  in  1  pmpcfg write strobe
cfg_idx  in  $clog2(PMP_ENTRIES)  pmpcfg entry index
cfg_wdata  in  8  {L, res[1:0], A[1:0], X, W, R}
addr_we  in  1  pmpaddr write strobe
addr_idx  in  $clog2(PMP_ENTRIES)  pmpaddr entry index
addr_wdata  in  32  pmpaddr value (physical address bits [33:2])
pmp_cfg_q  out  8*PMP_ENTRIES  current pmpcfg values, entry e at [8e+7:8e]
chan_valid  in  PMP_CHANNELS  request valid per channel
chan_addr  in  32*PMP_CHANNELS  byte address per channel
chan_type  in  3*PMP_CHANNELS  access type per channel, one-hot {X, W, R}
rsp_valid  out  PMP_CHANNELS  response valid, one cycle after chan_valid
rsp_err  out  PMP_CHANNELS  access fault, qualified by rsp_valid
fault_valid  out  1  a fault is captured
fault_addr  out  32  captured faulting address
fault_chan  out  $clog2(PMP_CHANNELS)+1  captured channel index
fault_type  out  3  captured access type
fault_clr  in  1  clear captured fault
err_count  out  ERR_CNT_W  saturating count of faulting responses

Behaviour:
- Reset: all pmpcfg = 0 (OFF, unlocked) and all pmpaddr = 0. rsp_valid, rsp_err, fault_valid, fault_addr, fault_chan, fault_type and err_count are all 0.
- Reset wins over every other input in the same cycle.
- Register writes take effect on the next clock edge. A check in the same cycle as a write uses the old values.
- pmpcfg write:
  - Ignored if the entry's L bit is set.
  - Reserved bits [6:5] are stored as 0.
  - W=1 with R=0 is stored as W=0.
- pmpaddr write to entry i is ignored if either:
  - cfg[i].L = 1, or
  - cfg[i+1].L = 1 and cfg[i+1].A = TOR (i+1 < PMP_ENTRIES).
- A lock is cleared only by rst.
- cfg_we and addr_we may assert in the same cycle. They are independent. Each lock check uses the pre-write values.
- Match, using the word address wa = {2'b00, addr[31:2]}:
  - A=OFF(0): no match.
  - A=TOR(1): addr[i-1] <= wa < addr[i]. For entry 0 the lower bound is 0. If addr[i-1] >= addr[i], no match.
  - A=NA4(2): wa == addr[i].
  - A=NAPOT(3): let t be the number of trailing ones in addr[i]. Match when wa and addr[i] agree on bits [31:t+1].
- Priority: the lowest-index matching entry decides. Fault if the requested type bit is 0 in that entry's {X, W, R}.
- No matching entry: no fault.
- Permissions apply regardless of L, because the core is machine-mode-only.
- chan_type that is not one-hot (including 0): fault.
- Pipeline:
  - Inputs are registered; the check runs on the registered request.
  - rsp_valid[c] and rsp_err[c] are valid exactly 1 cycle after chan_valid[c].
  - There is no backpressure. Channels are independent and fully pipelined (back-to-back every cycle).
  - rsp_err[c] = 0 whenever rsp_valid[c] = 0.
- Fault capture:
  - When fault_valid = 0 and any rsp_err is set, capture the lowest-index faulting channel's addr, index and type. Set fault_valid on the next edge.
  - While fault_valid = 1, further faults are not captured.
  - If fault_clr and a new rsp_err occur in the same cycle, the new fault is captured (fault_valid stays 1, fields are updated).
  - fault_clr alone clears fault_valid only. The other fault fields hold their last values.
- err_count: adds popcount(rsp_valid & rsp_err) each cycle and saturates at 2^ERR_CNT_W-1. It is not affected by fault_clr.

Test Plan:
- Reset then check: chan_valid=3'b111, all types R, any addr -> 1 cycle later rsp_valid=3'b111, rsp_err=0, fault_valid=0.
- NAPOT: entry0 addr=0x0000_01FF, cfg=0x19 (NAPOT, R only); i.e. 4 KB region at 0x0000_0000. Write at 0x0000_0100 -> err=1. Read at 0x0000_0FFC -> err=0. Write at 0x0000_1000 -> err=0 (no match).
- TOR priority: entry0 addr=0x400, cfg=0x0F (TOR RWX); entry1 addr=0x800, cfg=0x08 (TOR, none). Exec at 0x0800 -> err=0. Exec at 0x1000 -> err=1. Exec at 0x2000 -> err=0.
- Lock:
  - cfg1=0x88 (L, TOR). Then write addr0=0x123 -> ignored (stays old), write cfg1=0x0F -> ignored, write addr1 -> ignored.
  - After rst, all three writes take effect.
- Fault capture: ch2 faults at 0x3000 and ch0 faults at 0x1000 in the same cycle -> fault_chan=0, fault_addr=0x1000, err_count += 2.
  - Next cycle ch1 faults -> capture unchanged.
  - fault_clr together with a ch1 fault at 0x5000 -> fault_valid=1, fault_chan=1.
- err_count saturation (ERR_CNT_W=4): 20 consecutive single-channel faults -> err_count = 15 and holds. A mid-stream rst -> err_count=0 and rsp_valid=0 next cycle.
